// File: rtl/region_flash.sv
// Streams a clamped screen window out of frame memory in raster order and
// issues one plot per returned pixel. Transparent pixels can be skipped with a colour key.
module region_flash #(
  parameter int SCR_W      = 160,
  parameter int SCR_H      = 120,
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int ADDR_BITS  = 15,
  parameter int COLOR_BITS = 3,
  parameter int READ_LAT   = 1
) (
  input  logic                  Clck,
  input  logic                  Reset,
  input  logic                  in_cont_signal,
  input  logic                  next_fin_signal,
  input  logic [X_BITS-1:0]     win_x0,
  input  logic [Y_BITS-1:0]     win_y0,
  input  logic [X_BITS:0]       win_w,
  input  logic [Y_BITS:0]       win_h,
  input  logic                  key_en,
  input  logic [COLOR_BITS-1:0] key_colour,
  output logic [ADDR_BITS-1:0]  read_addr,
  input  logic [COLOR_BITS-1:0] read_data,
  output logic [X_BITS-1:0]     plot_x,
  output logic [Y_BITS-1:0]     plot_y,
  output logic [COLOR_BITS-1:0] plot_colour,
  output logic                  plot,
  output logic                  out_cont_signal,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int                   LAST       = READ_LAT - 1;
  localparam logic [X_BITS+1:0]    SCR_W_X    = (X_BITS+2)'(SCR_W);
  localparam logic [Y_BITS+1:0]    SCR_H_Y    = (Y_BITS+2)'(SCR_H);
  localparam logic [ADDR_BITS-1:0] SCR_W_A    = ADDR_BITS'(SCR_W);
  localparam logic [1:0]           DRAIN_LAST = 2'(READ_LAT - 1);

  state_t state_q, state_d;

  logic [X_BITS-1:0]     x0_q, x0_d;
  logic [X_BITS-1:0]     x_end_q, x_end_d;
  logic [Y_BITS-1:0]     y_end_q, y_end_d;
  logic [X_BITS-1:0]     x_q, x_d;
  logic [Y_BITS-1:0]     y_q, y_d;
  logic [ADDR_BITS-1:0]  row_q, row_d;
  logic                  key_en_q, key_en_d;
  logic [COLOR_BITS-1:0] key_q, key_d;
  logic [1:0]            dcnt_q, dcnt_d;

  // Pixel coordinates travel alongside the memory read so they meet the data.
  logic                  vld_q [READ_LAT];
  logic [X_BITS-1:0]     px_q  [READ_LAT];
  logic [Y_BITS-1:0]     py_q  [READ_LAT];

  // Window clamp is computed two bits wider so x0+w and y0+h never wrap.
  logic [X_BITS+1:0] x_sum, x_lim;
  logic [Y_BITS+1:0] y_sum, y_lim;
  logic              win_empty;
  logic              last_pix;
  logic              key_hit;

  always_comb begin
    x_sum     = {2'b00, win_x0} + {1'b0, win_w};
    y_sum     = {2'b00, win_y0} + {1'b0, win_h};
    x_lim     = (x_sum > SCR_W_X) ? SCR_W_X : x_sum;
    y_lim     = (y_sum > SCR_H_Y) ? SCR_H_Y : y_sum;
    win_empty = (win_w == '0) || (win_h == '0) ||
                ({2'b00, win_x0} >= SCR_W_X) || ({2'b00, win_y0} >= SCR_H_Y);
  end

  assign last_pix = (x_q == x_end_q) && (y_q == y_end_q);

  // State register
  always_ff @(posedge Clck) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_cont_signal && !out_cont_signal) state_d = S_LATCH;
      S_LATCH:  state_d = win_empty ? S_DONE : S_STREAM;
      S_STREAM: if (last_pix) state_d = S_DRAIN;
      S_DRAIN:  if (dcnt_q == DRAIN_LAST) state_d = S_DONE;
      S_DONE:   if (next_fin_signal) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_cont_signal = (state_q == S_DONE);
    busy            = (state_q != S_IDLE) && (state_q != S_DONE);
    read_addr       = row_q + ADDR_BITS'(x_q);
    key_hit         = key_en_q && (read_data == key_q);
    plot            = vld_q[LAST] && !key_hit;
    plot_x          = px_q[LAST];
    plot_y          = py_q[LAST];
    plot_colour     = vld_q[LAST] ? read_data : '0;
  end

  // Window capture and raster counters
  always_comb begin
    x0_d     = x0_q;
    x_end_d  = x_end_q;
    y_end_d  = y_end_q;
    x_d      = x_q;
    y_d      = y_q;
    row_d    = row_q;
    key_en_d = key_en_q;
    key_d    = key_q;
    dcnt_d   = dcnt_q;
    case (state_q)
      S_LATCH: begin
        x0_d     = win_x0;
        x_end_d  = X_BITS'(x_lim - 1'b1);
        y_end_d  = Y_BITS'(y_lim - 1'b1);
        x_d      = win_x0;
        y_d      = win_y0;
        row_d    = ADDR_BITS'(win_y0) * SCR_W_A;
        key_en_d = key_en;
        key_d    = key_colour;
        dcnt_d   = '0;
      end
      S_STREAM: begin
        if (x_q == x_end_q) begin
          x_d   = x0_q;
          y_d   = y_q + 1'b1;
          row_d = row_q + SCR_W_A;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      S_DRAIN: dcnt_d = dcnt_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clck) begin
    if (Reset) begin
      x0_q     <= '0;
      x_end_q  <= '0;
      y_end_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      row_q    <= '0;
      key_en_q <= 1'b0;
      key_q    <= '0;
      dcnt_q   <= '0;
    end else begin
      x0_q     <= x0_d;
      x_end_q  <= x_end_d;
      y_end_q  <= y_end_d;
      x_q      <= x_d;
      y_q      <= y_d;
      row_q    <= row_d;
      key_en_q <= key_en_d;
      key_q    <= key_d;
      dcnt_q   <= dcnt_d;
    end
  end

  always_ff @(posedge Clck) begin
    if (Reset) begin
      for (int i = 0; i < READ_LAT; i++) begin
        vld_q[i] <= 1'b0;
        px_q[i]  <= '0;
        py_q[i]  <= '0;
      end
    end else begin
      vld_q[0] <= (state_q == S_STREAM);
      px_q[0]  <= x_q;
      py_q[0]  <= y_q;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        px_q[i]  <= px_q[i-1];
        py_q[i]  <= py_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_region_flash.sv
// Drives two region_flash instances (read latency 1 and 3) with shared controls
// and compares their plot streams and completion timing against a raster model.
module tb_region_flash;

  localparam int SW   = 160;
  localparam int SH   = 120;
  localparam int NPIX = SW * SH;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_cont, next_fin, key_en;
  logic [7:0] win_x0;
  logic [6:0] win_y0;
  logic [8:0] win_w;
  logic [7:0] win_h;
  logic [2:0] key_colour;

  logic [14:0] raddr [2];
  logic [2:0]  rdata [2];
  logic [7:0]  px    [2];
  logic [6:0]  py    [2];
  logic [2:0]  pc    [2];
  logic        pl    [2];
  logic        oc    [2];
  logic        bz    [2];

  logic [2:0] mem [NPIX];
  logic [2:0] d1;
  logic [2:0] d3 [3];

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  int   done0, done1;
  pix_t got0[$], got1[$], exp_q[$];
  int   exp_n;

  region_flash #(.READ_LAT(LAT0)) dut0 (
    .Clck(clk), .Reset(rst), .in_cont_signal(in_cont), .next_fin_signal(next_fin),
    .win_x0(win_x0), .win_y0(win_y0), .win_w(win_w), .win_h(win_h),
    .key_en(key_en), .key_colour(key_colour),
    .read_addr(raddr[0]), .read_data(rdata[0]),
    .plot_x(px[0]), .plot_y(py[0]), .plot_colour(pc[0]), .plot(pl[0]),
    .out_cont_signal(oc[0]), .busy(bz[0])
  );

  region_flash #(.READ_LAT(LAT1)) dut1 (
    .Clck(clk), .Reset(rst), .in_cont_signal(in_cont), .next_fin_signal(next_fin),
    .win_x0(win_x0), .win_y0(win_y0), .win_w(win_w), .win_h(win_h),
    .key_en(key_en), .key_colour(key_colour),
    .read_addr(raddr[1]), .read_data(rdata[1]),
    .plot_x(px[1]), .plot_y(py[1]), .plot_colour(pc[1]), .plot(pl[1]),
    .out_cont_signal(oc[1]), .busy(bz[1])
  );

  // Frame memory models with 1- and 3-cycle read latency
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    d1    <= (int'(raddr[0]) < NPIX) ? mem[raddr[0]] : 3'd0;
    d3[0] <= (int'(raddr[1]) < NPIX) ? mem[raddr[1]] : 3'd0;
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign rdata[0] = d1;
  assign rdata[1] = d3[2];

  always @(negedge clk) begin
    if (mon_en) begin
      if (pl[0]) got0.push_back(pix_t'({px[0], py[0], pc[0]}));
      if (pl[1]) got1.push_back(pix_t'({px[1], py[1], pc[1]}));
      if (oc[0] && done0 < 0) done0 = cyc;
      if (oc[1] && done1 < 0) done1 = cyc;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d plot", tag, d), pl[d], 0);
      chk($sformatf("%s d%0d busy", tag, d), bz[d], 0);
      chk($sformatf("%s d%0d out_cont", tag, d), oc[d], 0);
      chk($sformatf("%s d%0d read_addr", tag, d), raddr[d], 0);
      chk($sformatf("%s d%0d plot_x", tag, d), px[d], 0);
      chk($sformatf("%s d%0d plot_y", tag, d), py[d], 0);
      chk($sformatf("%s d%0d plot_colour", tag, d), pc[d], 0);
    end
  endtask

  // Reference: every on-screen pixel of the window in raster order, minus keyed ones.
  task automatic build_exp(input int x0, input int y0, input int w, input int h,
                           input bit ken, input int kc);
    int xe, ye;
    exp_q.delete();
    exp_n = 0;
    xe = (x0 + w > SW) ? SW : x0 + w;
    ye = (y0 + h > SH) ? SH : y0 + h;
    for (int y = y0; y < ye; y++) begin
      for (int x = x0; x < xe; x++) begin
        exp_n++;
        if (!(ken && mem[y*SW + x] == 3'(kc)))
          exp_q.push_back(pix_t'({8'(x), 7'(y), mem[y*SW + x]}));
      end
    end
  endtask

  function automatic int diff_count(input pix_t a[$], input pix_t b[$], input int n);
    int bad = 0;
    if (a.size() < n || b.size() < n) return -1;
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) bad++;
    return bad;
  endfunction

  task automatic run_region(input string tag, input int x0, input int y0, input int w,
                            input int h, input bit ken, input int kc, input bit hold_fin);
    int c0, budget, lat0, lat1;
    build_exp(x0, y0, w, h, ken, kc);
    lat0 = (exp_n == 0) ? 2 : 2 + exp_n + LAT0;
    lat1 = (exp_n == 0) ? 2 : 2 + exp_n + LAT1;
    got0.delete();
    got1.delete();
    done0  = -1;
    done1  = -1;
    mon_en = 1'b1;
    @(negedge clk);
    win_x0 = 8'(x0); win_y0 = 7'(y0); win_w = 9'(w); win_h = 8'(h);
    key_en = ken; key_colour = 3'(kc);
    in_cont = 1'b1; next_fin = hold_fin;
    c0 = cyc;
    @(negedge clk);
    in_cont = 1'b0;
    budget = exp_n + 60;
    for (int i = 0; i < budget && (done0 < 0 || done1 < 0); i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk({tag, " busy0"}, bz[0], exp_n > 0);
        chk({tag, " busy1"}, bz[1], exp_n > 0);
        // Captured window must be immune to later input changes.
        win_x0 = 8'($urandom); win_y0 = 7'($urandom);
        win_w = 9'($urandom); win_h = 8'($urandom);
        key_en = 1'($urandom); key_colour = 3'($urandom);
      end
      if (i == 3) next_fin = 1'b0;
    end
    chk({tag, " latency0"}, done0 - c0, lat0);
    chk({tag, " latency1"}, done1 - c0, lat1);
    repeat (3) @(negedge clk);
    chk({tag, " hold0"}, oc[0], 1);
    chk({tag, " hold1"}, oc[1], 1);
    next_fin = 1'b1;
    @(negedge clk);
    next_fin = 1'b0;
    chk({tag, " release0"}, oc[0], 0);
    chk({tag, " release1"}, oc[1], 0);
    @(negedge clk);
    mon_en = 1'b0;
    chk({tag, " count0"}, got0.size(), exp_q.size());
    chk({tag, " count1"}, got1.size(), exp_q.size());
    chk({tag, " pixels0"}, diff_count(got0, exp_q, exp_q.size()), 0);
    chk({tag, " pixels1"}, diff_count(got1, exp_q, exp_q.size()), 0);
  endtask

  initial begin
    int c0;
    rst = 1'b1; in_cont = 1'b0; next_fin = 1'b0; key_en = 1'b0; key_colour = '0;
    win_x0 = '0; win_y0 = '0; win_w = '0; win_h = '0;
    for (int i = 0; i < NPIX; i++) mem[i] = 3'(i);
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    run_region("full", 0, 0, 160, 120, 1'b0, 0, 1'b0);
    run_region("clamp", 158, 118, 10, 10, 1'b0, 0, 1'b0);
    chk("clamp n", exp_q.size(), 4);
    run_region("empty_w", 5, 5, 0, 4, 1'b0, 0, 1'b0);
    run_region("empty_x", 200, 5, 4, 4, 1'b0, 0, 1'b0);

    for (int i = 0; i < NPIX; i++) mem[i] = 3'($urandom);
    mem[3*SW + 10] = 3'd0; mem[3*SW + 11] = 3'd5;
    mem[3*SW + 12] = 3'd0; mem[3*SW + 13] = 3'd7;
    run_region("key", 10, 3, 4, 1, 1'b1, 0, 1'b0);
    run_region("handshake", 40, 50, 4, 4, 1'b0, 0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      run_region($sformatf("rand%0d", r), $urandom_range(0, 170), $urandom_range(0, 125),
                 $urandom_range(0, 24), $urandom_range(0, 12), 1'($urandom), $urandom_range(0, 7),
                 1'b0);
    end

    // Reset while pixel 5 of an 8x8 region is being addressed.
    build_exp(20, 30, 8, 8, 1'b0, 0);
    got0.delete(); got1.delete();
    done0 = -1; done1 = -1;
    mon_en = 1'b1;
    @(negedge clk);
    win_x0 = 8'd20; win_y0 = 7'd30; win_w = 9'd8; win_h = 8'd8;
    key_en = 1'b0; in_cont = 1'b1; next_fin = 1'b0;
    c0 = cyc;
    @(negedge clk);
    in_cont = 1'b0;
    repeat (6) @(negedge clk);
    chk("midreset addr0", raddr[0], (30*SW + 20 + 5) + (cyc - c0 - 7));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("midreset");
    repeat (12) @(negedge clk);
    mon_en = 1'b0;
    chk("midreset count0", got0.size(), 6 - LAT0);
    chk("midreset count1", got1.size(), 6 - LAT1);
    chk("midreset pixels0", diff_count(got0, exp_q, 6 - LAT0), 0);
    chk("midreset pixels1", diff_count(got1, exp_q, 6 - LAT1), 0);
    chk("midreset done0", done0, -1);
    chk("midreset done1", done1, -1);

    run_region("fresh", 20, 30, 8, 8, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/region_flash.md
REGION_FLASH -- requirements
Module: region_flash

Interface
REQ-001 SHALL have parameters: SCR_W, default 160, screen width in pixels.
REQ-002 SHALL have parameters: SCR_H, default 120, screen height in pixels.
REQ-003 SHALL have parameters: X_BITS 8, Y_BITS 7, ADDR_BITS 15, COLOR_BITS 3, sizing coordinate, address and colour buses.
REQ-004 SHALL have parameters: READ_LAT, default 1, range 1..3, frame-memory read latency in cycles.
REQ-005 SHALL have ports, clock and reset first: Clck in 1, the single clock; Reset in 1, synchronous active-high reset.
REQ-006 SHALL have ports: in_cont_signal in 1, start request; next_fin_signal in 1, downstream continuation finished.
REQ-007 SHALL have ports: win_x0 in X_BITS, win_y0 in Y_BITS, win_w in X_BITS+1, win_h in Y_BITS+1, window origin and size.
REQ-008 SHALL have ports: key_en in 1, key_colour in COLOR_BITS, transparent-colour skip control.
REQ-009 SHALL have ports: read_addr out ADDR_BITS, read_data in COLOR_BITS, frame-memory read port.
REQ-010 SHALL have ports: plot_x out X_BITS, plot_y out Y_BITS, plot_colour out COLOR_BITS, plot out 1, plotter write port.
REQ-011 SHALL have ports: out_cont_signal out 1, region done; busy out 1, high outside IDLE and DONE.

Function
REQ-012 SHALL implement states IDLE, LATCH, STREAM, DRAIN, DONE.
REQ-013 IDLE -> LATCH when in_cont_signal=1 and out_cont_signal=0.
REQ-014 LATCH (1 cycle) SHALL capture win_*, key_en and key_colour; later input changes are ignored until the next IDLE.
REQ-015 LATCH SHALL clamp the window: x_end = min(x0+w, SCR_W)-1 and y_end = min(y0+h, SCR_H)-1, using widened arithmetic with no wrap.
REQ-016 LATCH -> DONE directly when w=0, h=0, x0>=SCR_W or y0>=SCR_H; zero plots result.
REQ-017 Otherwise LATCH -> STREAM with counters x=x0, y=y0.
REQ-018 STREAM SHALL issue one read_addr per cycle, read_addr = y*SCR_W + x, in raster order.
REQ-019 Ordering: x increments; at x=x_end, x returns to x0 and y increments.
REQ-020 STREAM -> DRAIN in the cycle after the address of (x_end, y_end) is issued.
REQ-021 (x,y,valid) SHALL be delayed READ_LAT stages so that plot_x, plot_y and plot_colour=read_data are aligned with the returning data.
REQ-022 plot SHALL be 1 for exactly one cycle per aligned pixel, except when key_en=1 and read_data=key_colour, in which case plot=0.
REQ-023 DRAIN SHALL last READ_LAT cycles, then go to DONE; the last plot occurs during DRAIN.
REQ-024 DONE SHALL hold out_cont_signal=1 until next_fin_signal=1; then out_cont_signal goes 0 and the state goes to IDLE on the same edge.
REQ-025 next_fin_signal SHALL be ignored outside DONE; in_cont_signal SHALL be ignored outside IDLE.
REQ-026 If in_cont_signal is still 1 in IDLE after DONE, a new region SHALL start; back-to-back operation is permitted.
REQ-027 Throughput SHALL be one pixel per cycle.
REQ-028 Latency from in_cont_signal accepted to out_cont_signal=1 SHALL be 2 + W*H + READ_LAT cycles for a clamped W x H region.

Reset
REQ-029 Reset=1 at a rising edge of Clck SHALL force IDLE with out_cont_signal=0, plot=0, busy=0, read_addr=0, plot_x=0, plot_y=0, plot_colour=0, and all pipeline valids cleared.
REQ-030 Reset SHALL take priority over all other inputs in any state; a region interrupted by reset is abandoned and produces no further plots.

Verification
REQ-031 Full screen, READ_LAT=1, x0=0, y0=0, w=160, h=120, memory data = addr[2:0] -> 19200 plots in raster order, each plot_colour = (y*160+x)[2:0], out_cont_signal=1 at cycle 19203.
REQ-032 Clamp case: x0=158, y0=118, w=10, h=10 -> exactly 4 plots at (158,118), (159,118), (158,119), (159,119).
REQ-033 Empty region: w=0, and separately x0=200 -> no plots, out_cont_signal=1 two cycles after start.
REQ-034 Key skip: key_en=1, key_colour=0, 4x1 region with data 0,5,0,7 -> plots only at x0+1 and x0+3; out_cont_signal timing is unchanged.
REQ-035 Reset mid-STREAM at pixel 5 of an 8x8 region, READ_LAT=3 -> plot=0 from the next cycle, no later plots, busy=0, and a fresh start works.
REQ-036 Handshake: hold next_fin_signal=1 during STREAM, then pulse it in DONE -> out_cont_signal stays 1 until the pulse and drops on that edge.
